// File: rtl/pe_operand_feeder.sv
// Operand sequencer for the dot-product PE: one command -> K paired buffer reads -> one PE stream.
// Optional FEEDER_PERF_CNT_EN adds busy-cycle and command counters (ports are tied to 0 otherwise).
module pe_operand_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_a_base,
  input  logic [ADDR_WIDTH-1:0] cmd_a_stride,
  input  logic [ADDR_WIDTH-1:0] cmd_b_base,
  input  logic [ADDR_WIDTH-1:0] cmd_b_stride,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] a_rdata,
  input  logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  pe_start,
  output logic                  pe_valid,
  output logic                  pe_last,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           perf_busy_cycles,
  output logic [15:0]           perf_cmds
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [ADDR_WIDTH-1:0] a_stride_q, a_stride_d, b_stride_q, b_stride_d;
  logic                  pe_valid_q, pe_valid_d;
  logic                  pe_start_q, pe_start_d;
  logic                  pe_last_q, pe_last_d;
  logic                  zdone_q, zdone_d;
  logic                  accept, issuing, last_issue;

  assign accept     = cmd_valid && (state_q == IDLE);
  assign issuing    = (state_q == ISSUE);
  assign last_issue = issuing && (idx_q == len_q - LEN_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    a_stride_d = a_stride_q;
    b_stride_d = b_stride_q;
    // Flags ride one cycle behind the read strobe so they line up with returned data.
    pe_valid_d = issuing;
    pe_start_d = issuing && (idx_q == '0);
    pe_last_d  = last_issue;
    zdone_d    = accept && (cmd_len == '0);
    case (state_q)
      IDLE: begin
        if (accept && (cmd_len != '0)) begin
          state_d    = ISSUE;
          idx_d      = '0;
          len_d      = cmd_len;
          a_addr_d   = cmd_a_base;
          b_addr_d   = cmd_b_base;
          a_stride_d = cmd_a_stride;
          b_stride_d = cmd_b_stride;
        end
      end
      ISSUE: begin
        if (last_issue) begin
          state_d = IDLE;
        end else begin
          idx_d    = idx_q + LEN_WIDTH'(1);
          a_addr_d = a_addr_q + a_stride_q;
          b_addr_d = b_addr_q + b_stride_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_stride_q <= '0;
      b_stride_q <= '0;
      pe_valid_q <= 1'b0;
      pe_start_q <= 1'b0;
      pe_last_q  <= 1'b0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      a_stride_q <= a_stride_d;
      b_stride_q <= b_stride_d;
      pe_valid_q <= pe_valid_d;
      pe_start_q <= pe_start_d;
      pe_last_q  <= pe_last_d;
      zdone_q    <= zdone_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rd_en     = issuing;
  assign a_addr    = a_addr_q;
  assign b_addr    = b_addr_q;
  assign pe_valid  = pe_valid_q;
  assign pe_start  = pe_start_q;
  assign pe_last   = pe_last_q;
  assign pe_a      = pe_valid_q ? a_rdata : '0;
  assign pe_b      = pe_valid_q ? b_rdata : '0;
  assign done      = (pe_valid_q && pe_last_q) || zdone_q;
  assign busy      = issuing || pe_valid_q;

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] busy_cnt_q, busy_cnt_d;
  logic [15:0] cmd_cnt_q, cmd_cnt_d;

  always_comb begin
    busy_cnt_d = busy ? busy_cnt_q + 32'd1 : busy_cnt_q;
    cmd_cnt_d  = done ? cmd_cnt_q + 16'd1 : cmd_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      busy_cnt_q <= '0;
      cmd_cnt_q  <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      cmd_cnt_q  <= cmd_cnt_d;
    end
  end

  assign perf_busy_cycles = busy_cnt_q;
  assign perf_cmds        = cmd_cnt_q;
`else
  assign perf_busy_cycles = '0;
  assign perf_cmds        = '0;
`endif

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Scoreboard bench for pe_operand_feeder: a command-level model queues expected reads,
// stream elements and done pulses; a negedge monitor pops and compares.
module tb_pe_operand_feeder;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int LW = 8;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic [AW-1:0] cmd_a_base = '0, cmd_a_stride = '0, cmd_b_base = '0, cmd_b_stride = '0;
  logic          rd_en;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_rdata = '0, b_rdata = '0;
  logic          pe_start, pe_valid, pe_last, busy, done;
  logic [DW-1:0] pe_a, pe_b;
  logic [31:0]   perf_busy_cycles;
  logic [15:0]   perf_cmds;

  always #5 clk = ~clk;

  pe_operand_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_a_base(cmd_a_base), .cmd_a_stride(cmd_a_stride), .cmd_b_base(cmd_b_base),
    .cmd_b_stride(cmd_b_stride), .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .pe_start(pe_start), .pe_valid(pe_valid),
    .pe_last(pe_last), .pe_a(pe_a), .pe_b(pe_b), .busy(busy), .done(done),
    .perf_busy_cycles(perf_busy_cycles), .perf_cmds(perf_cmds)
  );

  // Operand buffers: one-cycle read latency, garbage on the bus when not reading.
  logic [DW-1:0] a_mem [256];
  logic [DW-1:0] b_mem [256];
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[a_addr];
      b_rdata <= b_mem[b_addr];
    end else begin
      a_rdata <= $urandom;
      b_rdata <= $urandom;
    end
  end

  typedef struct { int cyc; logic [AW-1:0] a; logic [AW-1:0] b; } rd_t;
  typedef struct { int cyc; logic [DW-1:0] a; logic [DW-1:0] b; logic s; logic l; } pe_t;

  rd_t rd_q[$];
  pe_t pe_q[$];
  int  done_q[$];
  bit  exp_busy [MAXC];
  bit  exp_done [MAXC];
  int  cyc = 0;
  int  ready_at = 0;
  bit  started = 0;
  int  checks = 0;
  int  passed = 0;
  int  m_busy = 0;
  int  m_cmds = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
  endfunction

  // Reference model: period n is the stretch between clock edges n-1 and n.
  initial forever begin
    @(posedge clk);
    if (clr) begin
      rd_q.delete(); pe_q.delete(); done_q.delete();
      for (int c = cyc + 1; c < MAXC; c++) begin exp_busy[c] = 0; exp_done[c] = 0; end
      m_busy = 0; m_cmds = 0;
      ready_at = cyc + 1;
      started = 1;
    end else if (started) begin
      m_busy += int'(exp_busy[cyc]);
      m_cmds += int'(exp_done[cyc]);
      if (cmd_valid && cyc >= ready_at) begin
        int k;
        k = int'(cmd_len);
        if (k == 0) begin
          done_q.push_back(cyc + 1);
          exp_done[cyc + 1] = 1;
          ready_at = cyc + 1;
        end else begin
          for (int i = 0; i < k; i++) begin
            rd_t r; pe_t p;
            r.cyc = cyc + 1 + i;
            r.a = AW'(int'(cmd_a_base) + i * int'(cmd_a_stride));
            r.b = AW'(int'(cmd_b_base) + i * int'(cmd_b_stride));
            rd_q.push_back(r);
            p.cyc = cyc + 2 + i; p.a = a_mem[r.a]; p.b = b_mem[r.b];
            p.s = (i == 0); p.l = (i == k - 1);
            pe_q.push_back(p);
          end
          for (int c = cyc + 1; c <= cyc + k + 1; c++) exp_busy[c] = 1;
          done_q.push_back(cyc + k + 1);
          exp_done[cyc + k + 1] = 1;
          ready_at = cyc + k + 1;
        end
      end
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      bit e;
      chk("cmd_ready", cmd_ready, cyc >= ready_at);
      chk("busy", busy, exp_busy[cyc]);
      e = rd_q.size() > 0 && rd_q[0].cyc == cyc;
      chk("rd_en", rd_en, e);
      if (e) begin
        rd_t r;
        r = rd_q.pop_front();
        if (rd_en) begin chk("a_addr", a_addr, r.a); chk("b_addr", b_addr, r.b); end
      end
      e = pe_q.size() > 0 && pe_q[0].cyc == cyc;
      chk("pe_valid", pe_valid, e);
      if (e) begin
        pe_t p;
        p = pe_q.pop_front();
        if (pe_valid) begin
          chk("pe_a", pe_a, p.a); chk("pe_b", pe_b, p.b);
          chk("pe_start", pe_start, p.s); chk("pe_last", pe_last, p.l);
        end
      end else begin
        chk("pe_ab_idle", {pe_a, pe_b}, 64'd0);
      end
      e = done_q.size() > 0 && done_q[0] == cyc;
      chk("done", done, e);
      if (e) void'(done_q.pop_front());
`ifdef FEEDER_PERF_CNT_EN
      chk("perf_busy", perf_busy_cycles, m_busy[31:0]);
      chk("perf_cmds", perf_cmds, m_cmds[15:0]);
`else
      chk("perf_busy", perf_busy_cycles, 64'd0);
      chk("perf_cmds", perf_cmds, 64'd0);
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int k, input int ab, input int as_, input int bb, input int bs);
    bit acc;
    int guard;
    acc = 0; guard = 0;
    cmd_len = LW'(k); cmd_a_base = AW'(ab); cmd_a_stride = AW'(as_);
    cmd_b_base = AW'(bb); cmd_b_stride = AW'(bs);
    cmd_valid = 1'b1;
    do begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 400);
    if (!acc) chk("accept_timeout", 0, 1);
    cmd_valid = 1'b0;
    cmd_len = LW'($urandom); cmd_a_base = AW'($urandom); cmd_a_stride = AW'($urandom);
    cmd_b_base = AW'($urandom); cmd_b_stride = AW'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin a_mem[i] = $urandom; b_mem[i] = $urandom; end
    for (int i = 0; i < 4; i++) begin
      a_mem[8'h10 + i] = $shortrealtobits(shortreal'(i + 1));
      b_mem[8'h40 + 8 * i] = $shortrealtobits(shortreal'(2 * i + 1));
    end
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_pe_valid", pe_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pe_a", pe_a, 0);
    clr = 1'b0;
    idle(2);

    send(4, 'h10, 1, 'h40, 8);             // A 10..13, B 40,48,50,58
    idle(6);
    send(1, $urandom, $urandom, $urandom, $urandom);
    idle(3);
    send(0, $urandom, $urandom, $urandom, $urandom);
    idle(3);
    send(3, $urandom, $urandom, 'hF8, 8);  // B wraps F8,00,08
    send(3, $urandom, $urandom, 'hF8, 8);  // held back-to-back
    idle(6);

    send(6, $urandom, $urandom, $urandom, $urandom);
    idle(2);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    send(5, $urandom, $urandom, $urandom, $urandom);
    idle(8);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = (n == 20) ? 60 : $urandom_range(0, 12);
      send(k, $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end
    idle(80);

    chk("rd_q_drained", rd_q.size(), 0);
    chk("pe_q_drained", pe_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
